range_counter: RTL
==================

RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count/bound width in bits.
REQ-002 SHALL have parameter START_DEF, default 5, start bound loaded at reset.
REQ-003 SHALL have parameter END_DEF, default 67, end bound loaded at reset.
REQ-004 SHALL have parameter PASS_W, default 8, width of completed-pass counter.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 START_VAL  input  WIDTH  start bound captured on LOAD.
REQ-008 END_VAL  input  WIDTH  end bound captured on LOAD.
REQ-009 LOAD  input  1  capture START_VAL/END_VAL into bound registers.
REQ-010 GO  input  1  begin a counting run from the start bound.
REQ-011 ABORT  input  1  terminate a run, return to IDLE.
REQ-012 EN  input  1  count enable; 0 pauses RUN with COUNT held.
REQ-013 MODE  input  1  0 = one-shot (stop after one pass), 1 = continuous (wrap to start).
REQ-014 COUNT  output  WIDTH  current count value.
REQ-015 BUSY  output  1  high while in RUN.
REQ-016 DONE  output  1  one-cycle pulse on one-shot completion.
REQ-017 WRAP  output  1  one-cycle pulse on continuous-mode wrap.
REQ-018 PASSES  output  PASS_W  number of completed passes, saturating.

Function
REQ-019 SHALL implement states IDLE, RUN, FIN; all outputs registered.
REQ-020 Direction SHALL be derived from bounds: up (+1) when start_reg <= end_reg, else down (-1); no other step size.
REQ-021 LOAD in IDLE or FIN SHALL latch both bounds and set COUNT <= START_VAL on the same edge; LOAD in RUN SHALL be ignored.
REQ-022 GO in IDLE or FIN SHALL set COUNT <= start bound, PASSES <= 0, state <= RUN; GO in RUN SHALL be ignored.
REQ-023 LOAD and GO in the same cycle SHALL start the run from the newly presented START_VAL/END_VAL.
REQ-024 In RUN with EN=1 and COUNT != end_reg, COUNT SHALL step by one in the derived direction on each edge.
REQ-025 In RUN with EN=1, COUNT == end_reg, MODE=0: state <= FIN, COUNT holds end_reg, DONE=1 for exactly one cycle, PASSES increments.
REQ-026 In RUN with EN=1, COUNT == end_reg, MODE=1: COUNT <= start_reg, WRAP=1 for exactly one cycle, PASSES increments, state stays RUN.
REQ-027 PASSES SHALL saturate at 2^PASS_W-1; no wrap.
REQ-028 In RUN with EN=0, COUNT, PASSES, state SHALL hold; DONE/WRAP SHALL be 0.
REQ-029 ABORT in RUN SHALL set state <= IDLE with COUNT held; ABORT has priority over EN/completion in the same cycle; no DONE/WRAP that cycle.
REQ-030 start_reg == end_reg SHALL complete a pass on the first enabled RUN cycle (one-shot: DONE; continuous: WRAP every enabled cycle).
REQ-031 One pass SHALL take |end-start|+1 enabled RUN cycles; DONE/WRAP visible the cycle after the edge sampling COUNT == end_reg.
REQ-032 COUNT SHALL never leave the closed interval [start_reg, end_reg] (or its reverse) while in RUN; no modular rollover.
REQ-033 MODE SHALL be sampled every cycle; changing it mid-run affects only the next end-of-pass decision.
REQ-034 BUSY SHALL equal (state == RUN).

Reset
REQ-035 RST_N low SHALL asynchronously force: state IDLE, start_reg=START_DEF, end_reg=END_DEF, COUNT=START_DEF, BUSY=0, DONE=0, WRAP=0, PASSES=0.
REQ-036 Reset asserted mid-run SHALL abandon the run with no DONE/WRAP pulse; after release block waits in IDLE for GO.
REQ-037 First edge after RST_N deassertion SHALL be an ordinary edge (GO accepted).

Verification
REQ-038 Defaults, MODE=0, EN=1, GO pulse -> COUNT 5,6,...,67; DONE single pulse after 63 enabled cycles; state FIN; COUNT stays 67; PASSES=1.
REQ-039 LOAD START_VAL=10 END_VAL=3, GO, MODE=0 -> COUNT 10 down to 3, DONE once, 8 enabled cycles.
REQ-040 LOAD 250..255, MODE=1, run 20 enabled cycles -> COUNT 250..255 repeating, WRAP pulse each 6 cycles, PASSES=3; COUNT never reaches 0.
REQ-041 Defaults, EN toggled 1/0 every cycle -> same sequence as REQ-038, each value held during EN=0, DONE after 63 enabled cycles.
REQ-042 RST_N low at COUNT=30 mid-run -> immediately COUNT=5, BUSY=0, no DONE; ABORT at COUNT=40 -> IDLE, COUNT=40, no DONE.
REQ-043 LOAD 7..7, MODE=0, GO -> DONE on first enabled cycle, COUNT=7; GO with LOAD in RUN -> bounds unchanged.

Source files
------------

// File: rtl/range_counter.sv
// Bounded up/down counter with one-shot and continuous modes.
// Direction follows the loaded bounds; completed passes are counted with saturation.
module range_counter #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     START_DEF = WIDTH'(5),
    parameter logic [WIDTH-1:0]     END_DEF   = WIDTH'(67),
    parameter int unsigned          PASS_W    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [WIDTH-1:0]    START_VAL,
    input  logic [WIDTH-1:0]    END_VAL,
    input  logic                LOAD,
    input  logic                GO,
    input  logic                ABORT,
    input  logic                EN,
    input  logic                MODE,
    output logic [WIDTH-1:0]    COUNT,
    output logic                BUSY,
    output logic                DONE,
    output logic                WRAP,
    output logic [PASS_W-1:0]   PASSES
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    start_reg;
    logic [WIDTH-1:0]    end_reg;
    logic                count_up;
    logic                at_end;
    logic [PASS_W-1:0]   passes_next;

    // Bounds are frozen during RUN, so direction is stable for the whole run.
    assign count_up    = (start_reg <= end_reg);
    assign at_end      = (COUNT == end_reg);
    assign passes_next = (PASSES == '1) ? PASSES : PASSES + 1'b1;

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // mixing in blocking assignments would make the order of statements matter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            start_reg <= START_DEF;
            end_reg   <= END_DEF;
            COUNT     <= START_DEF;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            WRAP      <= 1'b0;
            PASSES    <= '0;
        end else begin
            DONE <= 1'b0;
            WRAP <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (LOAD) begin
                        start_reg <= START_VAL;
                        end_reg   <= END_VAL;
                        COUNT     <= START_VAL;
                    end
                    if (GO) begin
                        // A simultaneous LOAD must start from the bounds being presented now.
                        COUNT  <= LOAD ? START_VAL : start_reg;
                        PASSES <= '0;
                        state  <= RUN;
                        BUSY   <= 1'b1;
                    end
                end
                RUN: begin
                    if (ABORT) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (EN) begin
                        if (at_end) begin
                            PASSES <= passes_next;
                            if (MODE) begin
                                COUNT <= start_reg;
                                WRAP  <= 1'b1;
                            end else begin
                                state <= FIN;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end else if (count_up) begin
                            COUNT <= COUNT + 1'b1;
                        end else begin
                            COUNT <= COUNT - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
